// File: rtl/motor_pwm_driver.sv
// Purpose: turns the 3-bit motor command into H-bridge pins with soft-start, reversal dead time and STOP cut-off.
// Latency: cmd_q +1, pins/duty +2, ena/enb +3 cycles from the input edge.
// Backpressure: none; the command is sampled every cycle and the outputs drive board pins directly.

module motor_pwm_side #(
  parameter int DEAD_CYCLES   = 100000,
  parameter int RAMP_INTERVAL = 50000,
  parameter int RAMP_STEP     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tgt_on,
  input  logic       tgt_fwd,
  input  logic [7:0] tgt_duty,
  input  logic [7:0] pwm_cnt,
  output logic       pin_fwd,
  output logic       pin_rev,
  output logic       en,
  output logic       dead
);
  typedef enum logic [1:0] {S_OFF, S_DEAD, S_RUN} state_t;

  localparam logic [19:0] DEAD_LAST = 20'(DEAD_CYCLES - 1);
  localparam logic [19:0] RAMP_LAST = 20'(RAMP_INTERVAL - 1);

  state_t      state;
  logic        cur_fwd;
  logic [7:0]  duty;
  logic [19:0] dead_cnt;
  logic [19:0] ramp_cnt;
  logic [8:0]  duty_inc;
  logic [7:0]  duty_ramped;

  // Ninth bit keeps the step from wrapping before it is clamped to the target.
  assign duty_inc    = {1'b0, duty} + 9'(RAMP_STEP);
  assign duty_ramped = (duty_inc > {1'b0, tgt_duty}) ? tgt_duty : duty_inc[7:0];
  assign dead        = (state == S_DEAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_OFF;
      cur_fwd  <= 1'b0;
      duty     <= 8'd0;
      dead_cnt <= 20'd0;
      ramp_cnt <= 20'd0;
      pin_fwd  <= 1'b0;
      pin_rev  <= 1'b0;
      en       <= 1'b0;
    end else begin
      en <= (duty > pwm_cnt);
      case (state)
        S_OFF: begin
          if (tgt_on) begin
            state    <= S_RUN;
            cur_fwd  <= tgt_fwd;
            duty     <= 8'd0;
            ramp_cnt <= 20'd0;
            pin_fwd  <= tgt_fwd;
            pin_rev  <= !tgt_fwd;
          end
        end
        S_RUN: begin
          if (!tgt_on) begin
            state   <= S_OFF;
            duty    <= 8'd0;
            pin_fwd <= 1'b0;
            pin_rev <= 1'b0;
          end else if (tgt_fwd != cur_fwd) begin
            state    <= S_DEAD;
            duty     <= 8'd0;
            pin_fwd  <= 1'b0;
            pin_rev  <= 1'b0;
            dead_cnt <= 20'd0;
          end else if (tgt_duty > duty) begin
            if (ramp_cnt == RAMP_LAST) begin
              duty     <= duty_ramped;
              ramp_cnt <= 20'd0;
            end else begin
              ramp_cnt <= ramp_cnt + 20'd1;
            end
          end else begin
            duty     <= tgt_duty;
            ramp_cnt <= 20'd0;
          end
        end
        S_DEAD: begin
          // Target is only looked at on exit; a changing target never restarts the coast.
          if (!tgt_on) begin
            state    <= S_OFF;
            dead_cnt <= 20'd0;
          end else if (dead_cnt == DEAD_LAST) begin
            state    <= S_RUN;
            cur_fwd  <= tgt_fwd;
            duty     <= 8'd0;
            ramp_cnt <= 20'd0;
            dead_cnt <= 20'd0;
            pin_fwd  <= tgt_fwd;
            pin_rev  <= !tgt_fwd;
          end else begin
            dead_cnt <= dead_cnt + 20'd1;
          end
        end
        default: begin
          state   <= S_OFF;
          duty    <= 8'd0;
          pin_fwd <= 1'b0;
          pin_rev <= 1'b0;
        end
      endcase
    end
  end
endmodule

module motor_pwm_driver #(
  parameter int PWM_DIV       = 16,
  parameter int DEAD_CYCLES   = 100000,
  parameter int RAMP_INTERVAL = 50000,
  parameter int RAMP_STEP     = 8,
  parameter int DUTY_STRAIGHT = 200,
  parameter int DUTY_TURN     = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] auto_motor_state,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       ena,
  output logic       enb,
  output logic       dead_active
);
  localparam logic [7:0]  DUTY_S   = 8'(DUTY_STRAIGHT);
  localparam logic [7:0]  DUTY_T   = 8'(DUTY_TURN);
  localparam logic [19:0] DIV_LAST = 20'(PWM_DIV - 1);

  logic [2:0]  cmd_q;
  logic [19:0] div_cnt;
  logic [7:0]  pwm_cnt;
  logic        l_on, l_fwd, r_on, r_fwd;
  logic [7:0]  tgt_duty;
  logic        dead_l, dead_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= 3'd0;
      div_cnt <= 20'd0;
      pwm_cnt <= 8'd0;
    end else begin
      cmd_q <= auto_motor_state;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= 20'd0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        div_cnt <= div_cnt + 20'd1;
      end
    end
  end

  // Codes 5..7 fall through to the all-off default, same as STOP.
  always_comb begin
    l_on     = 1'b0;
    l_fwd    = 1'b0;
    r_on     = 1'b0;
    r_fwd    = 1'b0;
    tgt_duty = 8'd0;
    case (cmd_q)
      3'd1: begin l_on = 1'b1; l_fwd = 1'b1; r_on = 1'b1; r_fwd = 1'b1; tgt_duty = DUTY_S; end
      3'd2: begin l_on = 1'b1; l_fwd = 1'b0; r_on = 1'b1; r_fwd = 1'b0; tgt_duty = DUTY_S; end
      3'd3: begin l_on = 1'b1; l_fwd = 1'b0; r_on = 1'b1; r_fwd = 1'b1; tgt_duty = DUTY_T; end
      3'd4: begin l_on = 1'b1; l_fwd = 1'b1; r_on = 1'b1; r_fwd = 1'b0; tgt_duty = DUTY_T; end
      default: ;
    endcase
  end

  motor_pwm_side #(
    .DEAD_CYCLES(DEAD_CYCLES), .RAMP_INTERVAL(RAMP_INTERVAL), .RAMP_STEP(RAMP_STEP)
  ) u_left (
    .clk(clk), .rst(rst), .tgt_on(l_on), .tgt_fwd(l_fwd), .tgt_duty(tgt_duty),
    .pwm_cnt(pwm_cnt), .pin_fwd(in1), .pin_rev(in2), .en(ena), .dead(dead_l)
  );

  motor_pwm_side #(
    .DEAD_CYCLES(DEAD_CYCLES), .RAMP_INTERVAL(RAMP_INTERVAL), .RAMP_STEP(RAMP_STEP)
  ) u_right (
    .clk(clk), .rst(rst), .tgt_on(r_on), .tgt_fwd(r_fwd), .tgt_duty(tgt_duty),
    .pwm_cnt(pwm_cnt), .pin_fwd(in3), .pin_rev(in4), .en(enb), .dead(dead_r)
  );

  assign dead_active = dead_l | dead_r;
endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

Converts the 3-bit motor command from the autonomous driving stage into H-bridge drive signals for the left and right wheel pairs. Each side gets direction pins (IN1/IN2, IN3/IN4) and a PWM enable (ENA, ENB). Each side applies three protections:
- a soft-start duty ramp;
- a mandatory coast dead time before any direction reversal;
- immediate cut-off on STOP.

It sits directly downstream of the driving-algorithm block. Its outputs go straight to the board pins.

## Interface
Parameters:
- PWM_DIV, 16: clock cycles per PWM counter step; 8-bit PWM gives 100 MHz/16/256 ≈ 24.4 kHz.
- DEAD_CYCLES, 100000: coast cycles between opposite directions (1 ms).
- RAMP_INTERVAL, 50000: cycles between duty ramp steps.
- RAMP_STEP, 8: duty increment per ramp step (8-bit duty).
- DUTY_STRAIGHT, 200: target duty for FORWARD/BACKWARD.
- DUTY_TURN, 160: target duty for LEFT/RIGHT.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- auto_motor_state, in, 3: command. 0 STOP, 1 FORWARD, 2 BACKWARD, 3 LEFT, 4 RIGHT.
- in1, in2, out, 1 each: left bridge direction. Forward = 1/0, reverse = 0/1, coast = 0/0.
- in3, in4, out, 1 each: right bridge direction, same encoding.
- ena, enb, out, 1 each: left/right PWM enable.
- dead_active, out, 1: high while either side is in DEAD.

## Operation
- Input is registered once (cmd_q). Codes 5–7 decode as STOP.
- Per-side target decode:
  - FORWARD: L fwd, R fwd, DUTY_STRAIGHT.
  - BACKWARD: L rev, R rev, DUTY_STRAIGHT.
  - LEFT: L rev, R fwd, DUTY_TURN.
  - RIGHT: L fwd, R rev, DUTY_TURN.
  - STOP: both sides off, duty 0.
- PWM counter: a shared 8-bit pwm_cnt increments once every PWM_DIV cycles and wraps 255→0.
  - ena = (duty_L > pwm_cnt), registered; enb likewise.
  - Duty 0 gives constant low. Duty 255 gives 255/256 high.
- Per-side FSM, states OFF / DEAD / RUN. It holds cur_dir, duty (8 bits), dead_cnt and ramp_cnt (20 bits each).
  - OFF: pins 00, duty 0.
    - Target nonzero → RUN with cur_dir = target, duty 0, ramp_cnt 0.
  - RUN: pins from cur_dir.
    - Target STOP → OFF in one cycle; duty 0 and pins 00 the same cycle.
    - Target dir ≠ cur_dir → DEAD, with duty 0, pins 00, dead_cnt 0.
    - Same dir, target duty < duty → duty = target immediately.
    - Same dir, target duty > duty → ramp_cnt counts 0..RAMP_INTERVAL−1. On wrap, duty = min(duty+RAMP_STEP, target) with saturation and no 8-bit overflow.
  - DEAD: pins 00, duty 0, dead_cnt increments.
    - When dead_cnt == DEAD_CYCLES−1 → RUN with cur_dir = current target, duty 0, ramp_cnt 0.
    - Target changes during DEAD: the count continues and is not restarted. The target is sampled only at exit.
    - Target STOP during DEAD → OFF immediately.
- Sides are independent. FORWARD→RIGHT keeps the left side in RUN (duty drops 200→160) while the right side enters DEAD.
- Never are both pins of one bridge high. Pins never switch fwd↔rev without ≥ DEAD_CYCLES cycles of 00 between.

## Timing
- Reset state: in1..in4 = 0, ena = enb = 0, dead_active = 0, both FSMs OFF, pwm_cnt = 0, all counters 0.
- Latency: a command at input edge N lands in cmd_q at N+1. The FSM and pin update at N+2, and ena/enb follow at N+3.
- Reversal total: DEAD_CYCLES cycles of coast, then ramp from 0.
- Ramp 0→200 at defaults takes 25 steps × 50000 = 1.25 M cycles.
- Reset mid-ramp or mid-dead: everything returns to reset values on the next edge. No residual dead time is enforced after reset; pins are already 00.

## Test plan
- Reset: hold rst 3 cycles with cmd = FORWARD → all outputs 0. Release → at rst-release+2, in1/in3 = 1, duty 0, ena = 0.
- FORWARD ramp (RAMP_INTERVAL = 4, RAMP_STEP = 8) → duty 0,8,…,200, advancing every 4 cycles and then holding 200. ena high exactly 200 of every 256 pwm_cnt values.
- FORWARD at duty 200 → BACKWARD (DEAD_CYCLES = 10) → pins 00, ena/enb 0 and dead_active 1 for exactly 10 cycles. Then in2/in4 = 1 and the ramp restarts from 0.
- FORWARD→RIGHT → left keeps 1/0 with duty snapping to 160. Right coasts 10 cycles, then becomes 0/1 and ramps to 160.
- STOP mid-DEAD and mid-ramp → pins 00 and duty 0 two cycles after input. Codes 5, 6, 7 behave identically to STOP.
- During DEAD, cmd toggles BACKWARD→FORWARD→BACKWARD → dead count is not restarted, and the side exits into the direction present at exit.
